// File: rtl/fifo_write_arbiter_if.sv
// Bundle of requester handshakes, FIFO write port, grant status and beat statistics
// for fifo_write_arbiter. The master modport is the arbiter's view, slave is its environment.
interface fifo_write_arbiter_if #(
   parameter int DATA_WIDTH = 8,
   parameter int STAT_WIDTH = 16
);
   logic                  req0_valid;
   logic [DATA_WIDTH-1:0] req0_data;
   logic                  req0_last;
   logic                  req0_ready;

   logic                  req1_valid;
   logic [DATA_WIDTH-1:0] req1_data;
   logic                  req1_last;
   logic                  req1_ready;

   logic                  fifo_full;
   logic                  fifo_writeENABLE;
   logic [DATA_WIDTH:0]   fifo_writeData;

   logic [1:0]            grant;
   logic                  busy;

   logic                  stats_clear;
   logic [STAT_WIDTH-1:0] req0_count;
   logic [STAT_WIDTH-1:0] req1_count;

   modport master (
      input  req0_valid, req0_data, req0_last,
      input  req1_valid, req1_data, req1_last,
      input  fifo_full, stats_clear,
      output req0_ready, req1_ready,
      output fifo_writeENABLE, fifo_writeData,
      output grant, busy,
      output req0_count, req1_count
   );

   modport slave (
      output req0_valid, req0_data, req0_last,
      output req1_valid, req1_data, req1_last,
      output fifo_full, stats_clear,
      input  req0_ready, req1_ready,
      input  fifo_writeENABLE, fifo_writeData,
      input  grant, busy,
      input  req0_count, req1_count
   );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Burst-granular round-robin arbiter sharing one FIFO write port between two byte producers.
// Optional per-source saturating beat counters are enabled by defining ARB_STATS_EN.
module fifo_write_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4,
   parameter int STAT_WIDTH = 16
) (
   input logic                  clk,
   input logic                  reset,
   fifo_write_arbiter_if.master bus
);

   localparam int BeatWidth = $clog2(MAX_BURST) + 1;
   localparam logic [BeatWidth-1:0] LastBeat = BeatWidth'(MAX_BURST - 1);

   typedef enum logic [1:0] {
      IDLE,
      BURST0,
      BURST1
   } state_t;

   state_t                 state_q;
   logic                   lastServed_q;
   logic [BeatWidth-1:0]   beatCount_q;
   logic [BeatWidth-1:0]   beatCount_d;
   logic [1:0]             grant_q;
   logic                   wrEn_q;
   logic [DATA_WIDTH:0]    wrData_q;
   logic                   xfer0;
   logic                   xfer1;
   logic                   pick1;

   // Ready follows fifo_full combinationally so the almost-full margin is never eaten
   assign bus.req0_ready = grant_q[0] & ~bus.fifo_full;
   assign bus.req1_ready = grant_q[1] & ~bus.fifo_full;
   assign xfer0          = bus.req0_valid & bus.req0_ready;
   assign xfer1          = bus.req1_valid & bus.req1_ready;
   assign pick1          = (bus.req0_valid & bus.req1_valid) ? ~lastServed_q : bus.req1_valid;
   assign beatCount_d    = beatCount_q + BeatWidth'(1);

   assign bus.grant            = grant_q;
   assign bus.busy             = |grant_q;
   assign bus.fifo_writeENABLE = wrEn_q;
   assign bus.fifo_writeData   = wrData_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         lastServed_q <= 1'b1;
         beatCount_q  <= '0;
         grant_q      <= 2'b00;
         wrEn_q       <= 1'b0;
         wrData_q     <= '0;
      end else begin
         wrEn_q <= xfer0 | xfer1;
         if (xfer0) begin
            wrData_q <= {1'b0, bus.req0_data};
         end else if (xfer1) begin
            wrData_q <= {1'b1, bus.req1_data};
         end

         case (state_q)
            IDLE: begin
               if (!bus.fifo_full && (bus.req0_valid || bus.req1_valid)) begin
                  state_q     <= pick1 ? BURST1 : BURST0;
                  grant_q     <= pick1 ? 2'b10 : 2'b01;
                  beatCount_q <= '0;
               end
            end
            BURST0: begin
               if (xfer0) begin
                  if (bus.req0_last || beatCount_q == LastBeat) begin
                     state_q      <= IDLE;
                     grant_q      <= 2'b00;
                     lastServed_q <= 1'b0;
                  end else begin
                     beatCount_q <= beatCount_d;
                  end
               end
            end
            BURST1: begin
               if (xfer1) begin
                  if (bus.req1_last || beatCount_q == LastBeat) begin
                     state_q      <= IDLE;
                     grant_q      <= 2'b00;
                     lastServed_q <= 1'b1;
                  end else begin
                     beatCount_q <= beatCount_d;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               grant_q <= 2'b00;
            end
         endcase
      end
   end

`ifdef ARB_STATS_EN
   logic [STAT_WIDTH-1:0] req0Count_q;
   logic [STAT_WIDTH-1:0] req0Count_d;
   logic [STAT_WIDTH-1:0] req1Count_q;
   logic [STAT_WIDTH-1:0] req1Count_d;

   // Counters stick at all-ones rather than wrapping
   always_comb begin
      req0Count_d = req0Count_q;
      req1Count_d = req1Count_q;
      if (xfer0 && !(&req0Count_q)) begin
         req0Count_d = req0Count_q + STAT_WIDTH'(1);
      end
      if (xfer1 && !(&req1Count_q)) begin
         req1Count_d = req1Count_q + STAT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset || bus.stats_clear) begin
         req0Count_q <= '0;
         req1Count_q <= '0;
      end else begin
         req0Count_q <= req0Count_d;
         req1Count_q <= req1Count_d;
      end
   end

   assign bus.req0_count = req0Count_q;
   assign bus.req1_count = req1Count_q;
`else
   logic unusedStatsClear;

   assign unusedStatsClear = bus.stats_clear;
   assign bus.req0_count   = '0;
   assign bus.req1_count   = '0;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: directed vector table, hand-written corner
// sequences and randomized traffic, all compared against a transaction-level reference model.
module tb_fifo_write_arbiter;

   localparam int DW   = 8;
   localparam int MB   = 4;
   localparam int SW   = 5;
   localparam int SMAX = (1 << SW) - 1;

   typedef struct {
      logic          rst;
      logic          full;
      logic          clr;
      logic          v0;
      logic [DW-1:0] d0;
      logic          l0;
      logic          v1;
      logic [DW-1:0] d1;
      logic          l1;
   } stim_t;

   typedef struct {
      stim_t       s;
      logic [1:0]  eGrant;
      logic [1:0]  eReady;
      logic        eWe;
      logic [DW:0] eWd;
   } vec_t;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   fifo_write_arbiter_if #(.DATA_WIDTH(DW), .STAT_WIDTH(SW)) bus ();

   fifo_write_arbiter #(
      .DATA_WIDTH(DW),
      .MAX_BURST (MB),
      .STAT_WIDTH(SW)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int checks = 0;
   int errors = 0;
   int writesSeen = 0;
   stim_t curStim;

   // Reference model: who owns the port, beats taken so far, and the pending write
   int          mOwner;
   int          mBeats;
   int          mLast;
   bit          mWe;
   logic [DW:0] mWd;
   int          mCnt0;
   int          mCnt1;

   function automatic void modelReset();
      mOwner = -1;
      mBeats = 0;
      mLast  = 1;
      mWe    = 1'b0;
      mWd    = '0;
      mCnt0  = 0;
      mCnt1  = 0;
   endfunction

   function automatic void modelStep(input stim_t s);
      bit       xfer;
      bit       lastBeat;
      bit [1:0] v;
      if (s.rst) begin
         modelReset();
         return;
      end
      v    = {s.v1, s.v0};
      xfer = (mOwner >= 0) && !s.full && v[mOwner];
      mWe  = xfer;
      if (xfer) mWd = (mOwner == 0) ? {1'b0, s.d0} : {1'b1, s.d1};
`ifdef ARB_STATS_EN
      if (s.clr) begin
         mCnt0 = 0;
         mCnt1 = 0;
      end else if (xfer) begin
         if (mOwner == 0) mCnt0 = (mCnt0 < SMAX) ? mCnt0 + 1 : SMAX;
         else             mCnt1 = (mCnt1 < SMAX) ? mCnt1 + 1 : SMAX;
      end
`endif
      if (mOwner < 0) begin
         if (!s.full && v != 2'b00) begin
            mOwner = (v == 2'b11) ? 1 - mLast : (s.v0 ? 0 : 1);
            mBeats = 0;
         end
      end else if (xfer) begin
         mBeats++;
         lastBeat = (mOwner == 0) ? s.l0 : s.l1;
         if (lastBeat || mBeats == MB) begin
            mLast  = mOwner;
            mOwner = -1;
         end
      end
   endfunction

   function automatic stim_t mkStim(bit rst, bit full, bit clr, bit v0, logic [DW-1:0] d0,
                                    bit l0, bit v1, logic [DW-1:0] d1, bit l1);
      stim_t s;
      s.rst = rst; s.full = full; s.clr = clr;
      s.v0 = v0; s.d0 = d0; s.l0 = l0;
      s.v1 = v1; s.d1 = d1; s.l1 = l1;
      return s;
   endfunction

   task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input stim_t s);
      @(posedge clk);
      #1;
      reset          = s.rst;
      bus.fifo_full  = s.full;
      bus.stats_clear = s.clr;
      bus.req0_valid = s.v0;
      bus.req0_data  = s.d0;
      bus.req0_last  = s.l0;
      bus.req1_valid = s.v1;
      bus.req1_data  = s.d1;
      bus.req1_last  = s.l1;
   endtask

   task automatic checkOutput();
      logic [1:0] eg;
      @(negedge clk);
      eg = (mOwner == 0) ? 2'b01 : (mOwner == 1) ? 2'b10 : 2'b00;
      checkField("grant",  bus.grant, eg);
      checkField("busy",   bus.busy, mOwner >= 0);
      checkField("ready0", bus.req0_ready, (mOwner == 0) && !curStim.full);
      checkField("ready1", bus.req1_ready, (mOwner == 1) && !curStim.full);
      checkField("wrEn",   bus.fifo_writeENABLE, mWe);
      checkField("wrData", bus.fifo_writeData, mWd);
      checkField("count0", bus.req0_count, mCnt0);
      checkField("count1", bus.req1_count, mCnt1);
      if (bus.fifo_writeENABLE === 1'b1) writesSeen++;
      modelStep(curStim);
   endtask

   task automatic runCycle(input stim_t s);
      curStim = s;
      applyStimulus(s);
      checkOutput();
   endtask

   vec_t  vecs[12];
   stim_t idle;
   stim_t rstStim;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] simulation did not terminate");
   end

   initial begin
      int beats;
      int wStart;
      int src0;
      int src1;
      stim_t s;
      int fullSched[13] = '{0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};

      idle    = mkStim(0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0);
      rstStim = mkStim(1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0);

      // Blocked arbitration under almost-full, then a single req0 burst of three bytes
      vecs[0]  = '{idle,                                        2'b00, 2'b00, 1'b0, 9'h000};
      vecs[1]  = '{mkStim(0, 1, 0, 1, 8'hB0, 1, 1, 8'hC0, 1),   2'b00, 2'b00, 1'b0, 9'h000};
      vecs[2]  = '{mkStim(0, 1, 0, 1, 8'hB0, 1, 1, 8'hC0, 1),   2'b00, 2'b00, 1'b0, 9'h000};
      vecs[3]  = '{mkStim(0, 0, 0, 1, 8'hB0, 1, 1, 8'hC0, 1),   2'b00, 2'b00, 1'b0, 9'h000};
      vecs[4]  = '{mkStim(0, 0, 0, 1, 8'hB0, 1, 1, 8'hC0, 1),   2'b01, 2'b01, 1'b0, 9'h000};
      vecs[5]  = '{idle,                                        2'b00, 2'b00, 1'b1, 9'h0B0};
      vecs[6]  = '{mkStim(0, 0, 0, 1, 8'hA1, 0, 0, 8'h00, 0),   2'b00, 2'b00, 1'b0, 9'h0B0};
      vecs[7]  = '{mkStim(0, 0, 0, 1, 8'hA1, 0, 0, 8'h00, 0),   2'b01, 2'b01, 1'b0, 9'h0B0};
      vecs[8]  = '{mkStim(0, 0, 0, 1, 8'hA2, 0, 0, 8'h00, 0),   2'b01, 2'b01, 1'b1, 9'h0A1};
      vecs[9]  = '{mkStim(0, 0, 0, 1, 8'hA3, 1, 0, 8'h00, 0),   2'b01, 2'b01, 1'b1, 9'h0A2};
      vecs[10] = '{idle,                                        2'b00, 2'b00, 1'b1, 9'h0A3};
      vecs[11] = '{idle,                                        2'b00, 2'b00, 1'b0, 9'h0A3};

      reset = 1'b1;
      bus.fifo_full = 1'b0; bus.stats_clear = 1'b0;
      bus.req0_valid = 1'b0; bus.req0_data = '0; bus.req0_last = 1'b0;
      bus.req1_valid = 1'b0; bus.req1_data = '0; bus.req1_last = 1'b0;
      curStim = rstStim;
      repeat (2) @(posedge clk);
      modelReset();

      for (int i = 0; i < 12; i++) begin
         runCycle(vecs[i].s);
         checkField($sformatf("vec%0d_grant", i),  bus.grant, vecs[i].eGrant);
         checkField($sformatf("vec%0d_ready", i),  {bus.req1_ready, bus.req0_ready}, vecs[i].eReady);
         checkField($sformatf("vec%0d_wrEn", i),   bus.fifo_writeENABLE, vecs[i].eWe);
         checkField($sformatf("vec%0d_wrData", i), bus.fifo_writeData, vecs[i].eWd);
      end

      // Continuous contention without last: 4 beats each, one idle cycle between bursts
      runCycle(rstStim);
      src0 = 0;
      src1 = 0;
      for (int c = 0; c < 22; c++) begin
         runCycle(mkStim(0, 0, 0, 1, 8'($urandom), 0, 1, 8'($urandom), 0));
         if (bus.fifo_writeENABLE === 1'b1) begin
            if (bus.fifo_writeData[DW]) src1++;
            else                        src0++;
         end
      end
      checkField("contention_src0Writes", src0, 8);
      checkField("contention_src1Writes", src1, 8);

      // Almost-full raised after two beats of a req0 burst and held for five cycles
      runCycle(rstStim);
      wStart = writesSeen;
      beats  = 0;
      for (int c = 0; c < 13; c++) begin
         runCycle(mkStim(0, fullSched[c][0], 0, beats < 4, 8'(8'h30 + beats), 0, 0, 8'h00, 0));
         if (fullSched[c] == 1) checkField("fullHoldReady0", bus.req0_ready, 1'b0);
         if (curStim.v0 && bus.req0_ready === 1'b1) beats++;
      end
      runCycle(idle);
      checkField("fullHoldWrites", writesSeen - wStart, 4);

      // Reset lands on the cycle req1 beat 0x55 is accepted
      runCycle(rstStim);
      runCycle(mkStim(0, 0, 0, 0, 8'h00, 0, 1, 8'h54, 0));
      runCycle(mkStim(0, 0, 0, 0, 8'h00, 0, 1, 8'h54, 0));
      checkField("rstMid_req1Granted", bus.grant, 2'b10);
      runCycle(mkStim(1, 0, 0, 0, 8'h00, 0, 1, 8'h55, 0));
      checkField("rstMid_beatOffered", bus.req1_ready, 1'b1);
      runCycle(mkStim(0, 0, 0, 1, 8'h66, 1, 1, 8'h77, 1));
      checkField("rstMid_grantIdle", bus.grant, 2'b00);
      checkField("rstMid_noWrite", bus.fifo_writeENABLE, 1'b0);
      runCycle(mkStim(0, 0, 0, 1, 8'h66, 1, 1, 8'h77, 1));
      checkField("rstMid_req0First", bus.grant, 2'b01);
      runCycle(idle);
      runCycle(idle);
      runCycle(idle);

      // Beat statistics: ten req1 beats, clear against a beat, then saturation
      runCycle(rstStim);
      beats = 0;
      for (int c = 0; c < 60 && beats < 10; c++) begin
         runCycle(mkStim(0, 0, 0, 0, 8'h00, 0, 1, 8'($urandom), 0));
         if (bus.req1_ready === 1'b1) beats++;
      end
      checkField("stats_tenBeatsTaken", beats, 10);
      runCycle(idle);
`ifdef ARB_STATS_EN
      checkField("stats_tenBeats", bus.req1_count, 10);
`else
      checkField("stats_tenBeats", bus.req1_count, 0);
`endif
      runCycle(mkStim(0, 0, 1, 0, 8'h00, 0, 1, 8'h99, 0));
      checkField("stats_clrBeatTaken", bus.req1_ready, 1'b1);
      runCycle(idle);
      checkField("stats_cleared", bus.req1_count, 0);
      beats = 0;
      for (int c = 0; c < 150 && beats < 40; c++) begin
         runCycle(mkStim(0, 0, 0, 0, 8'h00, 0, 1, 8'($urandom), 0));
         if (bus.req1_ready === 1'b1) beats++;
      end
      checkField("stats_satBeatsTaken", beats, 40);
      runCycle(idle);
`ifdef ARB_STATS_EN
      checkField("stats_saturated", bus.req1_count, SMAX);
`else
      checkField("stats_saturated", bus.req1_count, 0);
`endif

      // Randomized traffic against the model
      runCycle(rstStim);
      for (int c = 0; c < 600; c++) begin
         s = mkStim($urandom_range(99) < 2, $urandom_range(99) < 25, $urandom_range(99) < 5,
                    $urandom_range(99) < 70, 8'($urandom), $urandom_range(99) < 30,
                    $urandom_range(99) < 70, 8'($urandom), $urandom_range(99) < 30);
         runCycle(s);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares the single write port of the bridge FIFO between two byte producers: UART RX (req0) and I2C read-back (req1).
- Round-robin arbitration at burst granularity.
- Tags each stored word with its source ID.
- Stops accepting data while the FIFO reports almost-full, so the FIFO's overflow margin is never consumed by this block.

Parameters:
- DATA_WIDTH, 8: payload width per requester.
- MAX_BURST, 4: max beats per grant before forced re-arbitration; legal range >= 1.
- STAT_WIDTH, 16: width of the per-source beat counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- req0_valid  in  1  requester 0 has a byte.
- req0_data  in  DATA_WIDTH  requester 0 byte.
- req0_last  in  1  byte ends requester 0 burst.
- req0_ready  out  1  requester 0 byte accepted this cycle when valid is high.
- req1_valid, req1_data, req1_last, req1_ready: same as req0, for requester 1.
- fifo_full  in  1  FIFO almost-full flag.
- fifo_writeENABLE  out  1  FIFO write strobe.
- fifo_writeData  out  DATA_WIDTH+1  {source_id, byte}; source_id 0 = req0, 1 = req1.
- grant  out  2  one-hot current burst owner; 00 when idle.
- busy  out  1  burst in progress (grant != 00).
- stats_clear  in  1  clear beat counters.
- req0_count  out  STAT_WIDTH  accepted beats from req0.
- req1_count  out  STAT_WIDTH  accepted beats from req1.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high (port reset), sampled on the rising edge of clk.
- Reset values:
  - state = IDLE, last_served = 1 (req0 wins first), beat counter = 0.
  - grant = 00, busy = 0, req0_ready = req1_ready = 0.
  - fifo_writeENABLE = 0, fifo_writeData = 0.
  - Counters = 0.
- FSM states: IDLE, BURST0, BURST1.
- IDLE:
  - Ready outputs are 0.
  - If fifo_full = 0 and at least one valid is high: go to BURSTi and clear the beat counter.
  - If both are valid, pick the requester that is not last_served.
  - If fifo_full = 1, stay in IDLE.
  - Arbitration costs exactly 1 idle cycle between bursts.
- BURSTi:
  - grant[i] = 1.
  - reqi_ready = !fifo_full (combinational); the other ready = 0.
  - Transfer occurs when reqi_valid && reqi_ready.
  - On transfer, increment the beat counter (width clog2(MAX_BURST)+1).
  - Burst ends on a transfer with reqi_last = 1, or on a transfer where the beat counter equals MAX_BURST-1.
  - At burst end: go to IDLE and set last_served = i.
  - A requester dropping valid mid-burst keeps the grant (lock until last or MAX_BURST).
  - fifo_full = 1 mid-burst: ready = 0, state and beat count held.
- Write latency:
  - A transfer in cycle N gives fifo_writeENABLE = 1 in cycle N+1.
  - fifo_writeData = {i, reqi_data captured at N} in cycle N+1.
  - fifo_writeENABLE is low in every other cycle; fifo_writeData holds its last value.
- MAX_BURST = 1: every transfer ends the burst; strict alternation under contention.
- Reset mid-burst: the burst is abandoned, the next cycle shows IDLE outputs, and a transfer registered in the reset cycle is dropped (no write strobe).
- Throughput: at most 1 write per cycle; at most MAX_BURST writes per MAX_BURST+1 cycles under continuous contention.

Optional Feature:
- Macro: ARB_STATS_EN.
- When defined:
  - req0_count and req1_count each increment on a transfer from their source.
  - Counters saturate at all-ones.
  - stats_clear = 1 zeroes both counters next cycle and takes precedence over a same-cycle increment (that beat is not counted).
- When undefined:
  - Counter outputs are constant 0.
  - stats_clear is ignored.
  - No counter flops are inferred.

Test Plan:
1. Reset; req0 sends 0xA1, 0xA2, 0xA3 with last on 0xA3; req1 idle -> grant = 01 the cycle after valid. fifo_writeENABLE high 3 consecutive cycles carrying 0x0A1, 0x0A2, 0x0A3, each one cycle after its accept. Then grant = 00.
2. Both valid continuously, last never set, MAX_BURST = 4 -> 4 req0 beats, 1 idle cycle, 4 req1 beats, 1 idle cycle, repeating. Every req1 word has bit 8 = 1.
3. req0 burst with fifo_full raised after 2 beats for 5 cycles -> req0_ready = 0 and no write strobes during those cycles. The remaining 2 beats complete after deassert; total 4 writes, no duplicates or losses.
4. reset asserted in the cycle req1 beat 0x55 is accepted mid-burst -> next cycle grant = 00 and fifo_writeENABLE = 0 (0x55 not written). With both valid after reset, req0 is granted first.
5. fifo_full = 1 while both requesters are valid in IDLE -> grant stays 00 and no ready is asserted. Deassert fifo_full -> grant = 01 the next cycle.
6. ARB_STATS_EN defined: 10 req1 beats -> req1_count = 10. Then stats_clear coincident with a req1 beat -> req1_count = 0 next cycle. Preset near max -> the counter stops at all-ones.
